// File: rtl/spi_master_ctrl.sv
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : SPI mode-0 master transaction engine, MSB first, gated by a
//                power-up init_done from the one-shot timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              ready,
    output logic              sclk,
    output logic              mosi,
    output logic              ss_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);

    localparam logic [2:0] S_WAIT_INIT = 3'd0;
    localparam logic [2:0] S_READY     = 3'd1;
    localparam logic [2:0] S_LEAD      = 3'd2;
    localparam logic [2:0] S_XFER      = 3'd3;
    localparam logic [2:0] S_TRAIL     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic              ready_q,   ready_d;
    logic              sclk_q,    sclk_d;
    logic              mosi_q,    mosi_d;
    logic              ss_n_q,    ss_n_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic              w_div_end;
    logic [DATA_W-1:0] w_shift_in;

    assign w_div_end  = (div_q == C_DIV_LAST);
    // miso is captured on the same edge that drives sclk high.
    assign w_shift_in = {shift_q[DATA_W-2:0], miso};

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ready_d    = ready_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            S_WAIT_INIT: begin
                if (init_done) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end
            end
            S_READY: begin
                if (start) begin
                    state_d = S_LEAD;
                    ready_d = 1'b0;
                    ss_n_d  = 1'b0;
                    mosi_d  = tx_data[DATA_W-1];
                    shift_d = tx_data;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_LEAD: begin
                if (w_div_end) begin
                    state_d = S_XFER;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    shift_d = w_shift_in;
                    bit_d   = bit_q + C_BIT_ONE;
                end else begin
                    div_d = div_q + C_DIV_ONE;
                end
            end
            S_XFER: begin
                if (w_div_end) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q != C_BIT_LAST) begin
                            mosi_d = shift_q[DATA_W-1];
                        end
                    end else if (bit_q == C_BIT_LAST) begin
                        // Final low half-period has elapsed.
                        state_d = S_TRAIL;
                    end else begin
                        sclk_d  = 1'b1;
                        shift_d = w_shift_in;
                        bit_d   = bit_q + C_BIT_ONE;
                    end
                end else begin
                    div_d = div_q + C_DIV_ONE;
                end
            end
            S_TRAIL: begin
                if (w_div_end) begin
                    state_d    = S_DONE;
                    div_d      = '0;
                    ss_n_d     = 1'b1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = shift_q;
                end else begin
                    div_d = div_q + C_DIV_ONE;
                end
            end
            S_DONE: begin
                state_d = S_READY;
                ready_d = 1'b1;
                bit_d   = '0;
            end
            default: begin
                state_d = S_WAIT_INIT;
                ready_d = 1'b0;
                ss_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_INIT;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            ready_q    <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign ready    = ready_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
//  Module      : tb_spi_master_ctrl
//  Description : Directed/randomized bench for spi_master_ctrl with a slave
//                model and a timing model derived from the transfer rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, init_done, start, miso, ready, sclk, mosi, ss_n, rx_valid;
    logic [7:0] tx_data, rx_data;
    logic       start2, ready2, sclk2, mosi2, ss_n2, rx_valid2;
    logic [1:0] tx2, rx2;

    logic       loopback;
    logic [7:0] slave_word;
    int         sbit = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Mode-0 slave: shifts its next bit out after each falling sclk edge.
    always @(negedge sclk or posedge ss_n) begin
        if (ss_n) sbit <= 0;
        else      sbit <= sbit + 1;
    end
    assign miso = loopback ? mosi : ((sbit < 8) ? slave_word[3'(7 - sbit)] : 1'b0);

    always @(posedge clk) cyc <= cyc + 1;

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .start(start),
        .tx_data(tx_data), .miso(miso), .ready(ready), .sclk(sclk),
        .mosi(mosi), .ss_n(ss_n), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    spi_master_ctrl #(.DATA_W(2), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .start(start2),
        .tx_data(tx2), .miso(mosi2), .ready(ready2), .sclk(sclk2),
        .mosi(mosi2), .ss_n(ss_n2), .rx_data(rx2), .rx_valid(rx_valid2)
    );

    // Expected sclk k cycles after acceptance: LEAD low, then alternating
    // half-periods starting high, then TRAIL/DONE low.
    function automatic logic exp_sclk(int k, int dw, int cd);
        if (k > cd && k <= cd + 2 * dw * cd) return (((k - cd - 1) / cd) % 2) == 0;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 300 && ready !== 1'b1; n++) @(negedge clk);
        chk("wait_ready", ready, 1);
    endtask

    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sl, input logic loop);
        int t0, rises, lastrise, sp_bad, ss_bad, sc_bad, st_bad, rxv_at, rxv_n;
        logic [7:0] dec, rxd;
        logic psclk, pmosi, rdy73, rdy74;
        wait_ready();
        loopback = loop; slave_word = sl; tx_data = tx; start = 1'b1;
        t0 = cyc; psclk = sclk; pmosi = mosi;
        rises = 0; lastrise = 0; sp_bad = 0; ss_bad = 0; sc_bad = 0; st_bad = 0;
        rxv_at = -1; rxv_n = 0; dec = '0; rxd = '0; rdy73 = 1'bx; rdy74 = 1'bx;
        for (int k = 1; k <= 74; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; tx_data = ~tx; end
            if (cyc != t0 + k) sc_bad++;
            if (ss_n !== ((k <= 72) ? 1'b0 : 1'b1)) ss_bad++;
            if (sclk !== exp_sclk(k, 8, 4)) sc_bad++;
            if (sclk === 1'b1 && psclk === 1'b0) begin
                rises++;
                dec = {dec[6:0], mosi};
                if (mosi !== pmosi) st_bad++;
                if (rises > 1 && k - lastrise != 8) sp_bad++;
                lastrise = k;
            end
            if (rx_valid === 1'b1) begin rxv_n++; if (rxv_at < 0) rxv_at = k; end
            if (k == 73) begin rxd = rx_data; rdy73 = ready; end
            if (k == 74) rdy74 = ready;
            psclk = sclk; pmosi = mosi;
        end
        chk("ss_n_window", ss_bad, 0);
        chk("sclk_wave", sc_bad, 0);
        chk("rise_count", rises, 8);
        chk("rise_spacing", sp_bad, 0);
        chk("mosi_stable", st_bad, 0);
        chk("mosi_decode", dec, tx);
        chk("rx_valid_latency", rxv_at, 73);
        chk("rx_valid_once", rxv_n, 1);
        chk("rx_data", rxd, loop ? tx : sl);
        chk("ready_at_T73", rdy73, 0);
        chk("ready_at_T74", rdy74, 1);
    endtask

    task automatic run_x2(input logic [1:0] tx);
        int sc_bad, rxv_at;
        logic [1:0] rxd;
        logic rdy;
        for (int n = 0; n < 50 && ready2 !== 1'b1; n++) @(negedge clk);
        chk("wait_ready2", ready2, 1);
        tx2 = tx; start2 = 1'b1; sc_bad = 0; rxv_at = -1; rxd = '0; rdy = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin start2 = 1'b0; tx2 = ~tx; end
            if (sclk2 !== exp_sclk(k, 2, 1)) sc_bad++;
            if (rx_valid2 === 1'b1 && rxv_at < 0) rxv_at = k;
            if (k == 7) rxd = rx2;
            if (k == 8) rdy = ready2;
        end
        chk("div1_sclk_wave", sc_bad, 0);
        chk("div1_rx_valid_latency", rxv_at, 7);
        chk("div1_rx_data", rxd, tx);
        chk("div1_ready_again", rdy, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad, t0;
        logic [7:0] q[$];
        int acc[$];
        int gap_bad, word_bad, got, hi_run, gaps, sp_bad;
        logic [7:0] expw;
        bit seen_low;

        rst_n = 1'b0; init_done = 1'b0; start = 1'b0; start2 = 1'b0;
        tx_data = '0; tx2 = '0; loopback = 1'b1; slave_word = '0;

        // Reset and init_done gating
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ss_n", ss_n, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_ready2", ready2, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            start = 1'($urandom);
            @(negedge clk);
            if (ss_n !== 1'b1 || ready !== 1'b0 || sclk !== 1'b0 || rx_valid !== 1'b0) bad++;
        end
        start = 1'b0;
        chk("gated_until_init", bad, 0);
        init_done = 1'b1;
        chk("ready_before_init_seen", ready, 0);
        @(negedge clk);
        chk("ready_after_init_seen", ready, 1);

        // Loopback and random slave words
        run_xfer(8'hA5, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) run_xfer(8'($urandom), 8'($urandom), 1'($urandom));
        init_done = 1'b0;
        run_xfer(8'h5E, 8'hE7, 1'b0);

        // start held high, tx_data changing every cycle
        wait_ready();
        loopback = 1'b1;
        gap_bad = 0; word_bad = 0; got = 0; hi_run = 0; gaps = 0; sp_bad = 0; seen_low = 0;
        for (int c = 0; c < 400; c++) begin
            if (c < 200) begin
                tx_data = 8'($urandom); start = 1'b1;
                if (ready === 1'b1) begin q.push_back(tx_data); acc.push_back(cyc); end
            end else begin
                start = 1'b0;
            end
            if (rx_valid === 1'b1) begin
                got++;
                if (q.size() == 0) word_bad++;
                else begin expw = q.pop_front(); if (rx_data !== expw) word_bad++; end
            end
            if (ss_n === 1'b1) hi_run++;
            else begin
                if (seen_low && hi_run != 0) begin gaps++; if (hi_run != 2) gap_bad++; end
                hi_run = 0; seen_low = 1;
            end
            if (c >= 200 && got == acc.size()) break;
            @(negedge clk);
        end
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 74) sp_bad++;
        chk("b2b_accepts", acc.size(), 3);
        chk("b2b_rx_count", got, 3);
        chk("b2b_words", word_bad, 0);
        chk("b2b_accept_spacing", sp_bad, 0);
        chk("b2b_gaps_seen", gaps, 2);
        chk("b2b_ss_gap", gap_bad, 0);

        // Slave returns 0x3C while master sends 0xC3
        run_xfer(8'hC3, 8'h3C, 1'b0);

        // Reset mid-transfer
        wait_ready();
        loopback = 1'b0; slave_word = 8'h96; tx_data = 8'h77; start = 1'b1; t0 = cyc;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("pre_reset_cycle", cyc, t0 + 30);
        chk("pre_reset_busy", ss_n, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ss_n", ss_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_rx_data", rx_data, 0);
        chk("abort_rx_valid", rx_valid, 0);
        chk("abort_ready", ready, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ready !== 1'b0 || rx_valid !== 1'b0 || ss_n !== 1'b1) bad++;
        end
        chk("abort_waits_init", bad, 0);
        init_done = 1'b1;
        chk("abort_ready_before_init", ready, 0);
        @(negedge clk);
        chk("abort_ready_after_init", ready, 1);

        // CLK_DIV=1, DATA_W=2 instance in loopback
        run_x2(2'b10);
        run_x2(2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI master transaction engine (mode 0: CPOL=0, CPHA=0, MSB first) for the SPI master/slave subsystem.
- Sits directly downstream of the power-up one-shot timer. It consumes the timer's done output as init_done and refuses all transfers until the timer has expired.
- Accepts one parallel word per start request, shifts it out on mosi while capturing miso, and returns the received word with a one-cycle valid pulse.

Parameters:
DATA_W, 8, bits per transfer; legal range ≥ 2.
CLK_DIV, 4, system clocks per SCLK half-period; legal range ≥ 1. Also sets the ss_n lead time and trail time.

Ports:
clk  input  1  system clock, all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
init_done  input  1  from the one-shot timer; high once settling time has expired
start  input  1  transfer request; accepted only when ready=1
tx_data  input  DATA_W  word to transmit; sampled in the cycle start is accepted
miso  input  1  serial data from the slave
ready  output  1  high when idle and a start will be accepted
sclk  output  1  SPI clock
mosi  output  1  serial data to the slave
ss_n  output  1  active-low slave select
rx_data  output  DATA_W  last received word; held until the next rx_valid
rx_valid  output  1  one-cycle pulse when rx_data updates

Behaviour:
- All outputs are registered.
- Reset values: ready=0, sclk=0, mosi=0, ss_n=1, rx_data=0, rx_valid=0, state=WAIT_INIT. Counters and shift register are cleared.
- WAIT_INIT:
  - Outputs hold their reset values.
  - When init_done=1 is sampled, go to READY; ready=1 from the next cycle.
  - start is ignored in this state.
- READY:
  - ready=1, ss_n=1, sclk=0.
  - When start=1 in cycle T: latch tx_data into the shift register and go to LEAD.
- LEAD:
  - Occupies cycles T+1 .. T+CLK_DIV.
  - ready=0, ss_n=0, sclk=0, mosi=tx_data[DATA_W-1].
- XFER:
  - Lasts 2*DATA_W*CLK_DIV cycles.
  - sclk toggles every CLK_DIV cycles, starting with a rising edge.
  - On each rising edge: shift miso into the shift-register LSB.
  - On each falling edge except the last: drive the next bit on mosi.
  - A bit counter counts DATA_W rising edges. XFER ends after the DATA_W-th falling edge, leaving sclk=0.
- TRAIL:
  - Lasts CLK_DIV cycles with ss_n=0, sclk=0, mosi held.
- DONE:
  - Single cycle: ss_n=1, rx_valid=1, rx_data=captured word, ready=0.
  - Next cycle: READY.
- Latency:
  - Start accepted in cycle T → rx_valid at T+1+(2*DATA_W+2)*CLK_DIV.
  - ready=1 again the following cycle.
  - Defaults: rx_valid at T+73, ready at T+74.
- miso is sampled in the same cycle sclk is driven high, i.e. at the slave's rising edge. No extra synchroniser inside this block.
- init_done is examined only in WAIT_INIT. A later low level on init_done is ignored; the timer only clears through reset.
- start is ignored while ready=0, including start held high through a transfer. A start in the cycle after DONE is accepted normally. Back-to-back transfers are separated by exactly one ss_n-high cycle (DONE) plus the acceptance cycle.
- tx_data changes after acceptance do not affect the transfer in progress.
- Reset mid-transfer:
  - On the next edge: ss_n=1, sclk=0, rx_valid=0, rx_data=0, state=WAIT_INIT.
  - No rx_valid for the aborted word.
  - Restart waits for init_done again.
- Counter widths:
  - Divider counter: $clog2(CLK_DIV) bits, minimum 1.
  - Bit counter: $clog2(DATA_W+1) bits.
  - Counters wrap only under explicit state control, never free-running.

Test Plan:
1. Reset gating: rst_n low 3 cycles; init_done low 20 cycles with start pulsed → ss_n stays 1, ready=0, no sclk edges. Raise init_done → ready=1 exactly one cycle after init_done is sampled.
2. Loopback: miso tied to mosi, tx_data=0xA5, defaults → rx_data=0xA5 with rx_valid at T+73. Exactly 8 sclk rising edges, each 8 cycles apart. ss_n low from T+1 through T+72.
3. Slave model returns 0x3C while tx_data=0xC3 → monitor decodes 0xC3 on mosi (MSB first, stable at every rising edge); rx_data=0x3C.
4. start held high for 200 cycles, tx_data changed every cycle → exactly one transfer per READY window. Each word equals the tx_data value at its acceptance cycle. Gap between consecutive transfers is 2 cycles.
5. Reset asserted at cycle T+30 of a transfer → next edge: ss_n=1, sclk=0, rx_data=0. No rx_valid. Ready returns only after init_done is seen again.
6. CLK_DIV=1, DATA_W=2: tx 2'b10 in loopback → sclk toggles every cycle; rx_valid at T+7; rx_data=2'b10.
